// File: rtl/gauss_pkg.sv
// Shared types and helpers for the Gaussian row filter: FSM encoding, size helpers
// and normalised (sum = 256) default coefficient sets for 5/7/9 taps, packed c[HALF]..c[0].
package gauss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [23:0] COEF_INIT_5 = {8'd16, 8'd64, 8'd96};
  localparam logic [31:0] COEF_INIT_7 = {8'd4, 8'd24, 8'd60, 8'd80};
  localparam logic [39:0] COEF_INIT_9 = {8'd1, 8'd8, 8'd28, 8'd56, 8'd70};

  function automatic int half_of(input int taps);
    return (taps - 1) / 2;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 4;
  endfunction

endpackage

// File: rtl/gauss_mac_pipe.sv
// Symmetric pre-add / multiply / round / saturate datapath with two register stages;
// valid, sol and eol ride alongside the data so they leave aligned with the pixel.
module gauss_mac_pipe
  import gauss_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TAPS      = 5,
  parameter int COEF_W    = 8,
  parameter int FRAC_BITS = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              vld_p0_i,
  input  logic                              sol_p0_i,
  input  logic                              eol_p0_i,
  input  logic [TAPS*DATA_W-1:0]            win_p0_i,
  input  logic [(half_of(TAPS)+1)*COEF_W-1:0] coef_i,
  output logic                              vld_o,
  output logic                              sol_o,
  output logic                              eol_o,
  output logic [DATA_W-1:0]                 data_o
);

  localparam int HALF   = half_of(TAPS);
  localparam int NC     = HALF + 1;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + 1 + COEF_W;

  function automatic logic [ACC_W-1:0] round_frac(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] t;
    t = {1'b0, a} + ((ACC_W+1)'(1) << (FRAC_BITS - 1));
    return ACC_W'(t >> FRAC_BITS);
  endfunction

  function automatic logic [DATA_W-1:0] sat_px(input logic [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > ACC_W'({DATA_W{1'b1}})) r = '1;
    else                           r = v[DATA_W-1:0];
    return r;
  endfunction

  logic [PROD_W-1:0] prod_d  [NC];
  logic [PROD_W-1:0] prod_p1 [NC];
  logic              vld_p1, sol_p1, eol_p1;
  logic [ACC_W-1:0]  acc_p1;
  logic              vld_p2, sol_p2, eol_p2;
  logic [DATA_W-1:0] data_p2;

  always_comb begin
    prod_d[0] = PROD_W'(win_p0_i[HALF*DATA_W +: DATA_W]) * PROD_W'(coef_i[0 +: COEF_W]);
    for (int k = 1; k < NC; k++) begin
      prod_d[k] = PROD_W'((DATA_W+1)'(win_p0_i[(HALF-k)*DATA_W +: DATA_W]) +
                          (DATA_W+1)'(win_p0_i[(HALF+k)*DATA_W +: DATA_W])) *
                  PROD_W'(coef_i[k*COEF_W +: COEF_W]);
    end
  end

  // p0 -> p1: pre-added products
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NC; k++) prod_p1[k] <= prod_d[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      sol_p1 <= 1'b0;
      eol_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0_i;
      sol_p1 <= vld_p0_i & sol_p0_i;
      eol_p1 <= vld_p0_i & eol_p0_i;
    end
  end

  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < NC; k++) acc_p1 = acc_p1 + ACC_W'(prod_p1[k]);
  end

  // p1 -> p2: rounded, saturated pixel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p2  <= 1'b0;
      sol_p2  <= 1'b0;
      eol_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      sol_p2 <= sol_p1;
      eol_p2 <= eol_p1;
      if (vld_p1) data_p2 <= sat_px(round_frac(acc_p1));
    end
  end

  assign vld_o  = vld_p2;
  assign sol_o  = sol_p2;
  assign eol_o  = eol_p2;
  assign data_o = data_p2;

endmodule

// File: rtl/gaussian_fir_1d.sv
// Streaming 1-D Gaussian row filter: line framing FSM, replicated-edge window and
// shadow/active coefficient banks feeding the gauss_mac_pipe datapath.
module gaussian_fir_1d
  import gauss_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TAPS      = 5,
  parameter int COEF_W    = 8,
  parameter int FRAC_BITS = 8,
  parameter logic [COEF_W*(half_of(TAPS)+1)-1:0] COEF_INIT = COEF_INIT_5
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              In_Sol,
  input  logic              In_Eol,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Coef_Wr,
  input  logic [3:0]        Coef_Addr,
  input  logic [COEF_W-1:0] Coef_Data,
  output logic              Out_Valid,
  output logic              Out_Sol,
  output logic              Out_Eol,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Err
);

  localparam int HALF = half_of(TAPS);
  localparam int NC   = HALF + 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] win_q [TAPS];
  logic [DATA_W-1:0] win_d [TAPS];
  logic [COEF_W-1:0] sh_q  [NC];
  logic [COEF_W-1:0] act_q [NC];
  logic [COEF_W-1:0] act_d [NC];
  logic [DATA_W-1:0] rep_q, rep_d, shift_px;
  logic [3:0]        s_q, s_d, fl_q, fl_d;
  logic              err_q, err_d;
  logic              vld_p0_q, vld_p0_d, sol_p0_q, sol_p0_d, eol_p0_q, eol_p0_d;
  logic              accept, load, shift, last;
  logic [TAPS*DATA_W-1:0] win_flat;
  logic [NC*COEF_W-1:0]   coef_flat;

  assign In_Ready = (state_q != ST_FLUSH);
  assign accept   = In_Valid & In_Ready;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    act_d    = act_q;
    rep_d    = rep_q;
    s_d      = s_q;
    fl_d     = fl_q;
    err_d    = err_q;
    vld_p0_d = 1'b0;
    sol_p0_d = 1'b0;
    eol_p0_d = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    last     = 1'b0;
    shift_px = Data_In;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (In_Sol) load = 1'b1;
          else        err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (In_Sol) begin
            err_d = 1'b1;
            load  = 1'b1;
          end else begin
            shift = 1'b1;
            if (In_Eol) begin
              rep_d   = Data_In;
              fl_d    = '0;
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        shift    = 1'b1;
        shift_px = rep_q;
        fl_d     = fl_q + 4'd1;
        if (fl_q == 4'(HALF - 1)) begin
          last    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new line replicates its first pixel across the whole window.
    if (load) begin
      for (int k = 0; k < TAPS; k++) win_d[k] = Data_In;
      act_d   = sh_q;
      rep_d   = Data_In;
      s_d     = '0;
      fl_d    = '0;
      state_d = In_Eol ? ST_FLUSH : ST_RUN;
    end

    if (shift) begin
      for (int k = 0; k < TAPS - 1; k++) win_d[k] = win_q[k+1];
      win_d[TAPS-1] = shift_px;
      if (s_q != 4'(HALF)) s_d = s_q + 4'd1;
      vld_p0_d = (s_q >= 4'(HALF - 1));
      sol_p0_d = (s_q == 4'(HALF - 1));
      eol_p0_d = last;
    end

    if (Coef_Wr && (Coef_Addr > 4'(HALF))) err_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      rep_q    <= '0;
      s_q      <= '0;
      fl_q     <= '0;
      err_q    <= 1'b0;
      vld_p0_q <= 1'b0;
      sol_p0_q <= 1'b0;
      eol_p0_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
      for (int k = 0; k < NC; k++) begin
        sh_q[k]  <= COEF_INIT[k*COEF_W +: COEF_W];
        act_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      s_q      <= s_d;
      fl_q     <= fl_d;
      err_q    <= err_d;
      vld_p0_q <= vld_p0_d;
      sol_p0_q <= sol_p0_d;
      eol_p0_q <= eol_p0_d;
      win_q    <= win_d;
      act_q    <= act_d;
      for (int k = 0; k < NC; k++) begin
        if (Coef_Wr && (Coef_Addr == 4'(k))) sh_q[k] <= Coef_Data;
      end
    end
  end

  always_comb begin
    win_flat  = '0;
    coef_flat = '0;
    for (int k = 0; k < TAPS; k++) win_flat[k*DATA_W +: DATA_W] = win_q[k];
    for (int k = 0; k < NC; k++)   coef_flat[k*COEF_W +: COEF_W] = act_q[k];
  end

  gauss_mac_pipe #(
    .DATA_W    (DATA_W),
    .TAPS      (TAPS),
    .COEF_W    (COEF_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .clk_i    (Clock),
    .rst_ni   (Rst),
    .vld_p0_i (vld_p0_q),
    .sol_p0_i (sol_p0_q),
    .eol_p0_i (eol_p0_q),
    .win_p0_i (win_flat),
    .coef_i   (coef_flat),
    .vld_o    (Out_Valid),
    .sol_o    (Out_Sol),
    .eol_o    (Out_Eol),
    .data_o   (Data_Out)
  );

  assign Err = err_q;

endmodule

// File: tb/tb_gaussian_fir_1d.sv
// Directed bench for gaussian_fir_1d: drives framed lines and compares the collected
// output stream against hand-computed filter results.
module tb_gaussian_fir_1d;

  logic       Clock = 1'b0;
  logic       Rst = 1'b0;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic       In_Sol = 1'b0;
  logic       In_Eol = 1'b0;
  logic [7:0] Data_In = '0;
  logic       Coef_Wr = 1'b0;
  logic [3:0] Coef_Addr = '0;
  logic [7:0] Coef_Data = '0;
  logic       Out_Valid, Out_Sol, Out_Eol, Err;
  logic [7:0] Data_Out;

  int n_chk  = 0;
  int n_pass = 0;
  int oq_d[$];
  int oq_s[$];
  int oq_e[$];
  int ex[$];

  gaussian_fir_1d dut (
    .Clock     (Clock),
    .Rst       (Rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Sol    (In_Sol),
    .In_Eol    (In_Eol),
    .Data_In   (Data_In),
    .Coef_Wr   (Coef_Wr),
    .Coef_Addr (Coef_Addr),
    .Coef_Data (Coef_Data),
    .Out_Valid (Out_Valid),
    .Out_Sol   (Out_Sol),
    .Out_Eol   (Out_Eol),
    .Data_Out  (Data_Out),
    .Err       (Err)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Out_Valid) begin
      oq_d.push_back(int'(Data_Out));
      oq_s.push_back(int'(Out_Sol));
      oq_e.push_back(int'(Out_Eol));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_q();
    oq_d.delete();
    oq_s.delete();
    oq_e.delete();
  endtask

  task automatic send(input int px, input bit sol, input bit eol);
    int t = 0;
    while (!In_Ready && t < 20) begin
      @(posedge Clock); #1;
      t++;
    end
    if (!In_Ready) chk("ready_timeout", 0, 1);
    In_Valid = 1'b1;
    In_Sol   = sol;
    In_Eol   = eol;
    Data_In  = 8'(px);
    @(posedge Clock); #1;
    In_Valid = 1'b0;
    In_Sol   = 1'b0;
    In_Eol   = 1'b0;
  endtask

  task automatic end_line(input string tag);
    int cnt = 0;
    while (!In_Ready && cnt < 10) begin
      cnt++;
      @(posedge Clock); #1;
    end
    chk({tag, "_flush_cycles"}, cnt, 2);
    repeat (6) @(posedge Clock);
    #1;
  endtask

  task automatic run_line(input string tag, input int p[$]);
    for (int i = 0; i < p.size(); i++) send(p[i], i == 0, i == p.size() - 1);
    end_line(tag);
  endtask

  task automatic check_out(input string tag, input int e[$]);
    chk({tag, "_count"}, oq_d.size(), e.size());
    for (int i = 0; i < e.size() && i < oq_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), oq_d[i], e[i]);
      chk($sformatf("%s_sol%0d", tag, i), oq_s[i], int'(i == 0));
      chk($sformatf("%s_eol%0d", tag, i), oq_e[i], int'(i == e.size() - 1));
    end
    clear_q();
  endtask

  task automatic coef_write(input int addr, input int val);
    Coef_Wr   = 1'b1;
    Coef_Addr = 4'(addr);
    Coef_Data = 8'(val);
    @(posedge Clock); #1;
    Coef_Wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_out_valid", int'(Out_Valid), 0);
    chk("rst_data_out", int'(Data_Out), 0);
    chk("rst_err", int'(Err), 0);
    chk("rst_in_ready", int'(In_Ready), 1);
    Rst = 1'b1;
    repeat (2) @(posedge Clock);
    #1;

    // Impulse line with default [1 4 6 4 1]/16
    run_line("impulse", '{0, 0, 0, 100, 0, 0});
    check_out("impulse", '{0, 6, 25, 38, 25, 6});
    chk("impulse_err", int'(Err), 0);

    // Ramp: edge replication on both borders
    run_line("ramp", '{0, 10, 20, 30, 40});
    check_out("ramp", '{4, 11, 20, 29, 36});

    // Single pixel line
    run_line("single", '{255});
    check_out("single", '{255});

    // Shadow write mid-line does not affect the running line
    send(100, 1, 0);
    send(100, 0, 0);
    Coef_Wr = 1'b1; Coef_Addr = 4'd0; Coef_Data = 8'd200;
    send(100, 0, 0);
    Coef_Wr = 1'b0;
    send(100, 0, 0);
    send(100, 0, 1);
    end_line("cw_line");
    check_out("cw_line", '{100, 100, 100, 100, 100});
    run_line("cw_sat", '{255, 255, 255, 255});
    check_out("cw_sat", '{255, 255, 255, 255});
    run_line("cw_ten", '{10, 10, 10, 10});
    check_out("cw_ten", '{14, 14, 14, 14});
    coef_write(0, 96);
    chk("cw_err", int'(Err), 0);

    // Valid without Sol while idle
    send(50, 0, 0);
    repeat (6) @(posedge Clock);
    #1;
    chk("nosol_count", oq_d.size(), 0);
    chk("nosol_err", int'(Err), 1);
    clear_q();

    // Sol restarts a line mid-way; only the new line produces output
    send(200, 1, 0);
    send(200, 0, 0);
    send(0, 1, 0);
    send(0, 0, 0);
    send(100, 0, 0);
    send(0, 0, 1);
    end_line("restart");
    check_out("restart", '{6, 25, 38, 25});

    // Reset during flush, with a pending shadow change that reset must discard
    coef_write(0, 200);
    send(100, 1, 0);
    send(100, 0, 0);
    send(100, 0, 0);
    send(100, 0, 1);
    chk("flush_state_ready", int'(In_Ready), 0);
    Rst = 1'b0;
    #1;
    chk("flrst_out_valid", int'(Out_Valid), 0);
    chk("flrst_data_out", int'(Data_Out), 0);
    chk("flrst_in_ready", int'(In_Ready), 1);
    chk("flrst_err", int'(Err), 0);
    clear_q();
    @(posedge Clock); #1;
    Rst = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    chk("flrst_no_outputs", oq_d.size(), 0);
    clear_q();
    run_line("post_rst", '{0, 0, 0, 100, 0, 0});
    check_out("post_rst", '{0, 6, 25, 38, 25, 6});
    chk("post_rst_err", int'(Err), 0);

    // Out-of-range coefficient address
    coef_write(5, 1);
    chk("bad_addr_err", int'(Err), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
